// File: rtl/fp_pkg.sv
// Shared floating-point field widths, constants and the int-to-float FSM state type.
package fp_pkg;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_BIAS  = 127;
    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    // Exponent of an unshifted 32-bit magnitude whose bit 31 is the leading one.
    localparam logic [FP_EXP_W-1:0] I2F_EXP_INIT = 8'(FP_BIAS + 31);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} i2f_state_t;
endpackage

// File: rtl/int_to_float_seq_if.sv
// Valid/ready request and response channels of the integer-to-float converter.
interface int_to_float_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_inexact;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_inexact
    );
    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_inexact
    );
endinterface

// File: rtl/fp_round_pack.sv
// Rounds a normalised 32-bit magnitude to 24 significant bits and packs an IEEE-754 single.
// Rounding mode: I2F_RNE_EN defined -> round-to-nearest-even, undefined -> truncate.
module fp_round_pack
    import fp_pkg::*;
(
    input  logic                sign,
    input  logic [FP_EXP_W-1:0] exp,
    input  logic [31:0]         mag,
    output logic [31:0]         out_data,
    output logic                inexact
);
    logic [FP_MAN_W-1:0] man;
    logic                guard;
    logic                sticky;

    assign man     = mag[30:8];
    assign guard   = mag[7];
    assign sticky  = |mag[6:0];
    assign inexact = guard | sticky;

`ifdef I2F_RNE_EN
    logic        round_up;
    logic [23:0] man_inc;

    assign round_up = guard & (sticky | man[0]);
    assign man_inc  = {1'b0, man} + 24'd1;

    always_comb begin
        out_data = {sign, exp, man};
        // Carry out of the 23-bit field means the significand reached 2.0.
        if (round_up)
            out_data = man_inc[23] ? {sign, exp + 8'd1, 23'd0} : {sign, exp, man_inc[22:0]};
        if (!mag[31])
            out_data = FP_POS_ZERO;
    end
`else
    always_comb begin
        out_data = {sign, exp, man};
        if (!mag[31])
            out_data = FP_POS_ZERO;
    end
`endif
endmodule

// File: rtl/int_to_float_seq.sv
// Iterative 32-bit integer to IEEE-754 single converter with a coarse/fine shift loop.
// Rounding mode chosen inside fp_round_pack by the I2F_RNE_EN macro.
module int_to_float_seq
    import fp_pkg::*;
#(
    parameter int STEP = 4
) (
    input logic clk,
    input logic rst,
    int_to_float_seq_if.slave bus
);
    i2f_state_t          state;
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [31:0]         mag;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [31:0]         out_data_q;
    logic                out_inexact_q;

    logic                sign_in;
    logic [31:0]         mag_in;
    logic [31:0]         rp_data;
    logic                rp_inexact;

    assign sign_in = bus.in_signed & bus.in_data[31];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign mag_in  = sign_in ? (~bus.in_data + 32'd1) : bus.in_data;

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_inexact = out_inexact_q;

    fp_round_pack u_round_pack (
        .sign     (sign),
        .exp      (exp),
        .mag      (mag),
        .out_data (rp_data),
        .inexact  (rp_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sign          <= 1'b0;
            exp           <= '0;
            mag           <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= FP_POS_ZERO;
            out_inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign       <= sign_in;
                        mag        <= mag_in;
                        exp        <= I2F_EXP_INIT;
                        in_ready_q <= 1'b0;
                        if (mag_in == 32'd0) begin
                            // Sign is dropped so a zero input never yields -0.
                            out_data_q    <= FP_POS_ZERO;
                            out_inexact_q <= 1'b0;
                            out_valid_q   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[31]) begin
                        state <= ROUND;
                    end else if (mag[31 -: STEP] == '0) begin
                        mag <= mag << STEP;
                        exp <= exp - FP_EXP_W'(STEP);
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 8'd1;
                    end
                end
                ROUND: begin
                    out_data_q    <= rp_data;
                    out_inexact_q <= rp_inexact;
                    out_valid_q   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed, table-driven bench for int_to_float_seq at the default STEP of 4.
module tb_int_to_float_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int_to_float_seq_if bus();

    int_to_float_seq #(.STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        sgn;
        logic [31:0] exp_data;
        logic        exp_inx;
        int          exp_lat;
    } vec_t;

`ifdef I2F_RNE_EN
    localparam logic [31:0] EXP_FFFF_U = 32'h4F80_0000;
    localparam logic [31:0] EXP_7FFF_S = 32'h4F00_0000;
    localparam logic [31:0] EXP_TIE_OD = 32'h4B80_0002;
`else
    localparam logic [31:0] EXP_FFFF_U = 32'h4F7F_FFFF;
    localparam logic [31:0] EXP_7FFF_S = 32'h4EFF_FFFF;
    localparam logic [31:0] EXP_TIE_OD = 32'h4B80_0001;
`endif

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req)
            $display("FAIL %s: actual %h required %h", name, act, req);
        else
            passed++;
    endtask

    // Issues one word and returns the cycle count (T+n) at which out_valid is first seen.
    task automatic start_conv(input logic [31:0] d, input logic s, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        int seen;
        logic [31:0] held;

        vecs[0]  = '{"zero_signed", 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1};
        vecs[1]  = '{"one_unsigned", 32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0, 13};
        vecs[2]  = '{"int_min_signed", 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3};
        vecs[3]  = '{"msb_unsigned", 32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3};
        vecs[4]  = '{"tie_even", 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 7};
        vecs[5]  = '{"tie_odd", 32'h0100_0003, 1'b0, EXP_TIE_OD, 1'b1, 7};
        vecs[6]  = '{"all_ones_unsigned", 32'hFFFF_FFFF, 1'b0, EXP_FFFF_U, 1'b1, 3};
        vecs[7]  = '{"minus_one_signed", 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 13};
        vecs[8]  = '{"three_unsigned", 32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0, 12};
        vecs[9]  = '{"minus_five_signed", 32'hFFFF_FFFB, 1'b1, 32'hC0A0_0000, 1'b0, 11};
        vecs[10] = '{"int_max_signed", 32'h7FFF_FFFF, 1'b1, EXP_7FFF_S, 1'b1, 4};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", bus.out_data, 32'h0);
        check("reset_out_inexact", 32'(bus.out_inexact), 32'd0);

        for (int i = 0; i < 11; i++) begin
            start_conv(vecs[i].data, vecs[i].sgn, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_data"}, bus.out_data, vecs[i].exp_data);
            check({vecs[i].name, "_inexact"}, 32'(bus.out_inexact), 32'(vecs[i].exp_inx));
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1 bus.out_ready = 1'b0;
            @(negedge clk);
            check({vecs[i].name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
            check({vecs[i].name, "_ready_back"}, 32'(bus.in_ready), 32'd1);
            check({vecs[i].name, "_data_retained"}, bus.out_data, vecs[i].exp_data);
        end

        // Backpressure: result held, new request ignored while DONE.
        start_conv(32'h0000_0100, 1'b0, lat);
        check("bp_latency", 32'(lat), 32'd11);
        check("bp_data", bus.out_data, 32'h4380_0000);
        held = bus.out_data;
        bus.in_data  = 32'h0000_0007;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid_held", 32'(bus.out_valid), 32'd1);
            check("bp_data_held", bus.out_data, held);
            check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("bp_no_stale_accept", 32'(seen), 32'd0);

        // Reset in the middle of the shift loop aborts the conversion.
        @(negedge clk);
        bus.in_data   = 32'h0000_0001;
        bus.in_signed = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("rst_no_result", 32'(seen), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/int_to_float_seq.md
Name: int_to_float_seq

Overview:
- Iterative converter from a 32-bit integer (signed two's-complement or unsigned) to an IEEE-754 single-precision word.
- Produces operands in exactly the format the floating add/sub datapath consumes (sign, 8-bit biased exponent, 23-bit mantissa).
- Sits in front of the floating unit on the integer-to-float path, behind a valid/ready handshake on both sides.
- Normalisation is a multi-cycle shift loop, trading latency for area.

Parameters:
- STEP, 4, coarse left-shift distance per NORM cycle; legal values 1, 2, 4, 8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  converter idle and able to accept.
- in_data  in  32  integer operand.
- in_signed  in  1  1: treat in_data as two's complement; 0: unsigned. Sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  32  IEEE-754 single result.
- out_inexact  out  1  result was rounded (discarded bits non-zero).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; out_inexact=0. rst asserted mid-conversion aborts it with no output. rst dominates every other event in the same cycle.
- States:
  - IDLE: in_ready=1.
  - NORM: in_ready=0.
  - ROUND: in_ready=0.
  - DONE: out_valid=1, out_data/out_inexact held stable until handshake.
- Accept in IDLE when in_valid&in_ready (cycle T):
  - Register sign = in_signed & in_data[31].
  - Register mag[31:0] = |in_data| (two's-complement negate when sign). 0x80000000 signed gives mag 0x80000000.
  - Register exp = 158 (127+31).
  - If mag==0: out_data=0x00000000, out_inexact=0, go DONE. out_valid high at T+1. Negative zero is never produced.
  - Otherwise go NORM.
- NORM, one action per cycle:
  - if mag[31]=1 → go ROUND, no shift;
  - else if mag[31:32-STEP]==0 → mag<<=STEP, exp-=STEP;
  - else → mag<<=1, exp-=1.
- With lz leading zeros, shifts = lz/STEP + lz%STEP and NORM occupies shifts+1 cycles.
- ROUND (one cycle):
  - Fields: man = mag[30:8]; G = mag[7]; S = |mag[6:0].
  - Round-up condition per Optional Feature.
  - Mantissa increment is 24-bit. On carry out, man=0 and exp+=1. Maximum result is 0x4F800000 (2^32).
  - out_inexact = G|S.
  - Register out_data = {sign, exp, man}; go DONE.
- Latency: out_valid first high at T+shifts+3 for nonzero input.
- DONE:
  - out_valid&out_ready → IDLE next cycle, out_valid=0.
  - out_data retains its last value after the handshake.
  - in_ready is not asserted in the same cycle as the handshake; no bypass, throughput is one conversion per busy period.
- in_valid while busy: ignored (in_ready=0); the source must hold its data.
- Exponent never underflows, minimum 127 for input 1, so no subnormal or overflow encodings are produced.

Optional Feature:
- Macro I2F_RNE_EN.
- Defined: round-to-nearest-even; round up when G&(S|man[0]).
- Undefined: truncation toward zero; never round up. out_inexact is still reported as G|S.
- Latency is identical in both builds.

Decomposition:
- Shared package fp_pkg:
  - FP_EXP_W=8, FP_MAN_W=23, FP_BIAS=127, FP_POS_ZERO=32'h0.
  - I2F_EXP_INIT=158.
  - State enum i2f_state_t {IDLE, NORM, ROUND, DONE}.
- One natural combinational sub-module, fp_round_pack. Inputs sign, exp, mag[31:0]; outputs {out_data, inexact}. Holds the macro-dependent rounding so the FSM stays build-agnostic.

Test Plan:
- Zero: in_data=0x00000000, in_signed=1 → out_data 0x00000000, inexact 0, out_valid at T+1.
- Minimum values:
  - in_data=0x00000001 unsigned, STEP=4 → out_data 0x3F800000 at T+13 (lz=31: 7+3 shifts).
  - in_data=0x80000000, in_signed=1 → 0xCF000000, inexact 0, out_valid at T+3.
- Rounding:
  - in_data=0x01000001 unsigned → 0x4B800000, inexact 1 (tie, even lsb, no round-up).
  - in_data=0xFFFFFFFF unsigned → with I2F_RNE_EN 0x4F800000 (mantissa carry); without it 0x4F7FFFFF; inexact 1 in both.
- Sign: in_data=0xFFFFFFFF, in_signed=1 → 0xBF800000; same word with in_signed=0 → the unsigned result above.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles → out_valid/out_data stable, in_ready=0, a new in_valid is not accepted.
  - Assert rst during NORM → next cycle IDLE, out_valid=0, in_ready=1, no stale result appears.
